// File: rtl/sar_capture_fifo_pkg.sv
// sar_pkg: shared types and defaults for the SAR conversion sequencer.
//   sar_state_e    - sequencer FSM states (IDLE/START/BUSY/GAP)
//   SAR_DATA_W     - default SAR result width
//   SAR_MIN_PERIOD - default floor on the conversion period
//   SAR_TIMEOUT    - default cnvst-to-eoc cycle allowance
//   avg_last()     - last sample index of an averaging block (2^a - 1)
package sar_pkg;

  localparam int SAR_DATA_W     = 10;
  localparam int SAR_MIN_PERIOD = 16;
  localparam int SAR_TIMEOUT    = 63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } sar_state_e;

  function automatic logic [2:0] avg_last(input logic [1:0] a);
    logic [2:0] r;
    case (a)
      2'd0:    r = 3'd0;
      2'd1:    r = 3'd1;
      2'd2:    r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// sar_sync_fifo: synchronous show-ahead FIFO.
//   clk, rst       - clock, synchronous active-high reset
//   push/push_data - write request and word; ignored when full unless popping
//   pop            - consume head word; ignored when empty
//   rd_data        - head word, valid whenever empty is low
//   full/empty     - occupancy flags
//   level          - occupancy, 0..DEPTH
module sar_sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // When full, a push is only taken if the head leaves in the same cycle;
  // the write lands on the slot being vacated.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sar_capture_fifo.sv
// sar_capture_fifo: SAR conversion sequencer, averager and result buffer.
//   clk, rst      - system clock, synchronous active-high reset
//   en            - run enable
//   period        - cycles between cnvst pulses (floored at MIN_PERIOD)
//   avg_log2      - 2^avg_log2 samples averaged per output word
//   sar_in/eoc_in - SAR result and its end-of-conversion strobe
//   cnvst         - one-cycle registered conversion start
//   out_data/out_valid/out_ready - show-ahead FIFO head with handshake
//   level         - FIFO occupancy
//   ovf           - sticky: word dropped on full FIFO
//   err_timeout   - sticky: conversion never finished
//   clr_flags     - clears both sticky flags (a coincident set wins)
//   busy          - sequencer not idle
module sar_capture_fifo
  import sar_pkg::*;
#(
  parameter int DATA_W     = SAR_DATA_W,
  parameter int DEPTH      = 4,
  parameter int PERIOD_W   = 8,
  parameter int MIN_PERIOD = SAR_MIN_PERIOD,
  parameter int TIMEOUT    = SAR_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PERIOD_W-1:0]       period,
  input  logic [1:0]                avg_log2,
  input  logic [DATA_W-1:0]         sar_in,
  input  logic                      eoc_in,
  output logic                      cnvst,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  output logic                      err_timeout,
  input  logic                      clr_flags,
  output logic                      busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = DATA_W + 3;

  sar_state_e          state, state_nxt;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] per_floor;
  logic [1:0]          avg_q;
  logic [PERIOD_W-1:0] pcnt;
  logic [TW-1:0]       tcnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;
  logic [2:0]          scnt;
  logic                capture;
  logic                tmo;
  logic                push_q;
  logic [DATA_W-1:0]   push_data_q;
  logic                cnvst_q;
  logic                ovf_q;
  logic                err_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;

  assign per_floor = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
  assign sum       = acc + {3'b000, sar_in};

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = START;
      START: state_nxt = BUSY;
      BUSY: begin
        if (eoc_in) begin
          capture   = 1'b1;
          state_nxt = GAP;
        end else if (tcnt == TW'(TIMEOUT)) begin
          tmo       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // >= rather than == so a timeout longer than the period still exits.
        if (pcnt >= per_q - PERIOD_W'(1)) state_nxt = en ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      per_q       <= PERIOD_W'(MIN_PERIOD);
      avg_q       <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      acc         <= '0;
      scnt        <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      cnvst_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnvst_q <= (state == START);

      // The START cycle counts as 0, so START-to-START spacing is per_q.
      if (state == START)  pcnt <= PERIOD_W'(1);
      else if (pcnt != '1) pcnt <= pcnt + PERIOD_W'(1);

      if (state == START)     tcnt <= '0;
      else if (state == BUSY) tcnt <= tcnt + TW'(1);

      push_q <= 1'b0;
      if (state == IDLE) begin
        per_q <= per_floor;
        avg_q <= avg_log2;
        acc   <= '0;
        scnt  <= '0;
      end else if (capture) begin
        if (scnt == avg_last(avg_q)) begin
          push_q      <= 1'b1;
          push_data_q <= DATA_W'(sum >> avg_q);
          acc         <= '0;
          scnt        <= '0;
        end else begin
          acc  <= sum;
          scnt <= scnt + 3'd1;
        end
      end

      if (tmo)            err_q <= 1'b1;
      else if (clr_flags) err_q <= 1'b0;

      if (drop)           ovf_q <= 1'b1;
      else if (clr_flags) ovf_q <= 1'b0;
    end
  end

  assign pop  = out_ready & ~fifo_empty;
  assign drop = push_q & fifo_full & ~pop;

  sar_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .rd_data   (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign out_valid   = ~fifo_empty;
  assign cnvst       = cnvst_q;
  assign ovf         = ovf_q;
  assign err_timeout = err_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sar_capture_fifo.sv
module tb_sar_capture_fifo;

  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] period;
  logic [1:0]    avg_log2;
  logic [DW-1:0] sar_in;
  logic          eoc_in;
  logic          cnvst;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          err_timeout;
  logic          clr_flags;
  logic          busy;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int cnv_cyc = 0;

  always #5 clk = ~clk;

  sar_capture_fifo #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .PERIOD_W   (PW),
    .MIN_PERIOD (16),
    .TIMEOUT    (63)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period      (period),
    .avg_log2    (avg_log2),
    .sar_in      (sar_in),
    .eoc_in      (eoc_in),
    .cnvst       (cnvst),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .ovf         (ovf),
    .err_timeout (err_timeout),
    .clr_flags   (clr_flags),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cnvst();
    int n = 0;
    do begin
      tick();
      n++;
    end while (cnvst !== 1'b1 && n < 300);
    chk("cnvst_seen", 32'(cnvst), 32'd1);
    cnv_cyc = cyc;
  endtask

  // SAR model: eoc with sample dly cycles after the current point.
  task automatic conv(input logic [DW-1:0] s, input int dly);
    repeat (dly) tick();
    sar_in = s;
    eoc_in = 1'b1;
    tick();
    eoc_in = 1'b0;
    sar_in = '0;
  endtask

  task automatic restart(input logic [1:0] a, input logic [PW-1:0] p);
    int n = 0;
    en = 1'b0;
    do begin
      tick();
      n++;
    end while (busy !== 1'b0 && n < 300);
    chk("idle_reached", 32'(busy), 32'd0);
    avg_log2  = a;
    period    = p;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    en        = 1'b1;
  endtask

  initial begin
    int prev;
    int n;
    int hits;

    rst = 1'b1; en = 1'b0; period = 8'd20; avg_log2 = 2'd0;
    sar_in = '0; eoc_in = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cnvst", 32'(cnvst), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_err",   32'(err_timeout), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);

    // Period 20, pass-through, eoc 14 cycles after cnvst
    out_ready = 1'b1;
    en = 1'b1;
    tick();
    chk("en_cnvst_1", 32'(cnvst), 32'd0);
    tick();
    chk("en_cnvst_2", 32'(cnvst), 32'd1);
    cnv_cyc = cyc;
    for (int k = 0; k < 3; k++) begin
      conv(10'h2A5, 14);
      chk("cap_early", 32'(out_valid), 32'd0);
      tick();
      chk("cap_valid", 32'(out_valid), 32'd1);
      chk("cap_data",  32'(out_data), 32'h2A5);
      prev = cnv_cyc;
      wait_cnvst();
      chk("spacing20", 32'(cyc - prev), 32'd20);
    end

    // Averaging by 4: 100,101,102,104 -> 101
    out_ready = 1'b0;
    restart(2'd2, 8'd20);
    wait_cnvst(); conv(10'd100, 14); tick(); chk("avg_none1", 32'(out_valid), 32'd0);
    wait_cnvst(); conv(10'd101, 14); tick(); chk("avg_none2", 32'(out_valid), 32'd0);
    wait_cnvst(); conv(10'd102, 14); tick(); chk("avg_none3", 32'(out_valid), 32'd0);
    wait_cnvst(); conv(10'd104, 14);
    chk("avg_early", 32'(out_valid), 32'd0);
    tick();
    chk("avg_valid", 32'(out_valid), 32'd1);
    chk("avg_data",  32'(out_data), 32'd101);
    chk("avg_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("avg_popped", 32'(out_valid), 32'd0);

    // Overflow: six results into a depth-4 FIFO with no consumer
    restart(2'd0, 8'd20);
    for (int i = 0; i < 6; i++) begin
      wait_cnvst();
      conv(10'h100 + 10'(i), 14);
      tick();
      if (i == 3) begin
        chk("ovf_lvl4",   32'(level), 32'd4);
        chk("ovf_before", 32'(ovf), 32'd0);
      end
    end
    chk("ovf_lvl_sat", 32'(level), 32'd4);
    chk("ovf_set",     32'(ovf), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'h100 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Timeout: no eoc, period 80
    restart(2'd0, 8'd80);
    wait_cnvst();
    repeat (63) tick();
    chk("tmo_before", 32'(err_timeout), 32'd0);
    tick();
    chk("tmo_at64", 32'(err_timeout), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (cnvst !== 1'b1 && n < 100);
    chk("tmo_next_cnvst", 32'(64 + n), 32'd80);
    chk("tmo_no_word", 32'(level), 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("tmo_clr", 32'(err_timeout), 32'd0);
    repeat (62) tick();
    chk("tmo2_before", 32'(err_timeout), 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("tmo_set_wins", 32'(err_timeout), 32'd1);

    // en dropped during BUSY: sample still captured, then idle
    restart(2'd0, 8'd20);
    wait_cnvst();
    repeat (3) tick();
    en = 1'b0;
    chk("endrop_busy", 32'(busy), 32'd1);
    conv(10'h155, 11);
    tick();
    chk("endrop_valid", 32'(out_valid), 32'd1);
    chk("endrop_data",  32'(out_data), 32'h155);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("endrop_idle", 32'(busy), 32'd0);
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cnvst === 1'b1) hits++;
    end
    chk("endrop_no_cnvst", 32'(hits), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-BUSY with three words queued
    restart(2'd0, 8'd20);
    for (int i = 0; i < 3; i++) begin
      wait_cnvst();
      conv(10'h0F0 + 10'(i), 14);
      tick();
    end
    chk("pre_rst_level", 32'(level), 32'd3);
    wait_cnvst();
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_cnvst", 32'(cnvst), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_ovf",   32'(ovf), 32'd0);
    chk("midrst_err",   32'(err_timeout), 32'd0);
    chk("midrst_busy",  32'(busy), 32'd0);
    rst = 1'b0;
    en  = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
